// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: valid/ready bundle between N producers, the mux and one consumer.
// STREAM_MUX_PKT_LOCK_EN adds per-channel in_last and the registered out_last.
interface stream_mux_rr_if #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int SELW = 2
);
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [W-1:0]    out_data;
   logic            out_valid;
   logic            out_ready;
   logic [SELW-1:0] out_sel;
`ifdef STREAM_MUX_PKT_LOCK_EN
   logic [N-1:0]    in_last;
   logic            out_last;
   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_sel, out_last
   );
   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_sel, out_last
   );
`else
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_sel
   );
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_sel
   );
`endif
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel round-robin stream mux with one registered output stage.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_rr #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int SELW = 2
) (
   input logic           clk,
   input logic           rst,
   stream_mux_rr_if.slave s
);
   logic [SELW-1:0] r_ptr, r_sel, w_g;
   logic [W-1:0]    r_data;
   logic            r_valid, w_load, w_any;
`ifdef STREAM_MUX_PKT_LOCK_EN
   logic            r_last, r_lock;
`endif
   assign w_load = ~r_valid | s.out_ready;
   // Scan from farthest to nearest so the channel closest after ptr wins.
   always_comb begin
      w_g   = r_ptr;
      w_any = 1'b0;
      for (int k = N; k >= 1; k--) begin
         if (s.in_valid[(int'(r_ptr) + k) % N]) begin
            w_g   = SELW'((int'(r_ptr) + k) % N);
            w_any = 1'b1;
         end
      end
`ifdef STREAM_MUX_PKT_LOCK_EN
      if (r_lock) begin
         w_g   = r_ptr;
         w_any = s.in_valid[r_ptr];
      end
`endif
   end
   assign s.in_ready  = (w_load && w_any && !rst) ? (N'(1) << w_g) : '0;
   assign s.out_data  = r_data;
   assign s.out_valid = r_valid;
   assign s.out_sel   = r_sel;
`ifdef STREAM_MUX_PKT_LOCK_EN
   assign s.out_last  = r_last;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sel   <= '0;
         r_ptr   <= SELW'(N - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
         r_last  <= 1'b0;
         r_lock  <= 1'b0;
`endif
      end else if (w_load) begin
         r_valid <= w_any;
         if (w_any) begin
            r_data <= s.in_data[int'(w_g)*W +: W];
            r_sel  <= w_g;
            r_ptr  <= w_g;
`ifdef STREAM_MUX_PKT_LOCK_EN
            r_last <= s.in_last[w_g];
            r_lock <= ~s.in_last[w_g];
`endif
         end
      end
   end
endmodule
